shift_add_multiplier: RTL and testbench

- Sequential signed 8x8 two's-complement multiplier datapath and control for the lab multiplier.
- Owns the X/A/B registers, the latched multiplicand S and the control FSM. Drives the 9-bit sign-extending add/subtract stage (add_sub) and consumes its sum and carry-extension bit.
- The 16-bit product is left in {A,B}, with X holding the sign. Results go to the hex displays and LEDs.

---
 rtl/shift_add_multiplier.sv | 166 ++++++++++++++++
 tb/tb_shift_add_multiplier.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential signed WIDTH x WIDTH shift-add multiplier.
// The product lands in {A,B}, and X holds the sign-extension bit.

module add_sub (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       fn,
    output logic [7:0] s,
    output logic       x
);
    logic [8:0] sum_s;

    // Nine-bit sign-extended add (fn=0) or subtract (fn=1).
    always_comb begin
        sum_s = {a[7], a} + ({b[7], b} ^ {9{fn}}) + {8'd0, fn};
        s     = sum_s[7:0];
        x     = sum_s[8];
    end
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             x_r, x_nxt_s;
    logic [WIDTH-1:0] a_r, a_nxt_s;
    logic [WIDTH-1:0] b_r, b_nxt_s;
    logic [WIDTH-1:0] s_r, s_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             busy_r, done_r;
    logic             fn_s;
    logic [WIDTH-1:0] sum_s;
    logic             cx_s;

    // The final partial product carries negative weight, so it is subtracted.
    assign fn_s = (cnt_r == CNT_LAST);

    generate
        if (WIDTH == 8) begin : g_add_sub
            add_sub u_add_sub (
                .a  (a_r),
                .b  (s_r),
                .fn (fn_s),
                .s  (sum_s),
                .x  (cx_s)
            );
        end else begin : g_inline
            logic [WIDTH:0] sum_ext_s;
            assign sum_ext_s = {a_r[WIDTH-1], a_r}
                             + ({s_r[WIDTH-1], s_r} ^ {(WIDTH+1){fn_s}})
                             + {{WIDTH{1'b0}}, fn_s};
            assign sum_s = sum_ext_s[WIDTH-1:0];
            assign cx_s  = sum_ext_s[WIDTH];
        end
    endgenerate

    // Next-state and datapath update selection.
    always_comb begin
        state_nxt_s = state_r;
        x_nxt_s     = x_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        s_nxt_s     = s_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (ClearA_LoadB) begin
                    b_nxt_s = Din;
                    x_nxt_s = 1'b0;
                    a_nxt_s = {WIDTH{1'b0}};
                end else if (Run) begin
                    s_nxt_s     = Din;
                    x_nxt_s     = 1'b0;
                    a_nxt_s     = {WIDTH{1'b0}};
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (b_r[0]) begin
                    x_nxt_s = cx_s;
                    a_nxt_s = sum_s;
                end else begin
                    a_nxt_s = a_r;
                end
                state_nxt_s = SHIFT;
            end
            SHIFT: begin
                a_nxt_s = {x_r, a_r[WIDTH-1:1]};
                b_nxt_s = {a_r[0], b_r[WIDTH-1:1]};
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    state_nxt_s = ADD;
                end
            end
            DONE: begin
                if (ClearA_LoadB) begin
                    b_nxt_s = Din;
                    x_nxt_s = 1'b0;
                    a_nxt_s = {WIDTH{1'b0}};
                end else if (!Run) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath registers and registered status flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            x_r     <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            x_r     <= x_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            s_r     <= s_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ADD) || (state_nxt_s == SHIFT);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    assign Aval = a_r;
    assign Bval = b_r;
    assign Xval = x_r;
    assign Busy = busy_r;
    assign Done = done_r;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench: stimulus queues expected {X,A,B}, and a monitor checks each Done.

module tb_shift_add_multiplier;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b0;
    logic       ClearA_LoadB = 1'b0;
    logic [7:0] Din = 8'd0;
    logic [7:0] Aval, Bval;
    logic       Xval, Busy, Done;

    int tests = 0;
    int fails = 0;
    logic [16:0] expq[$];
    logic        done_q = 1'b0;
    int          busy_cnt = 0;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
        .Din(Din), .Aval(Aval), .Bval(Bval), .Xval(Xval), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each Done rising edge pops one expected product and checks Busy length.
    always @(negedge Clk) begin
        if (Done && !done_q) begin
            if (expq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = expq.pop_front();
                check("product", {15'd0, Xval, Aval, Bval}, {15'd0, e});
                check("busy_cycles", busy_cnt, 32'd16);
            end
            busy_cnt = 0;
        end else if (Busy) begin
            busy_cnt++;
        end else if (!Done) begin
            busy_cnt = 0;
        end
        done_q = Done;
    end

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] d);
        ClearA_LoadB = 1'b1;
        Din = d;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] d, input logic [16:0] exp,
                          input int hold, input bit disturb);
        int i;
        expq.push_back(exp);
        Run = 1'b1;
        Din = d;
        i = 0;
        @(negedge Clk);
        i = 1;
        while (!Done && i < 40) begin
            if (disturb && i == 3) begin
                ClearA_LoadB = 1'b1;
                Din = 8'hFF;
            end
            if (disturb && i == 6) begin
                ClearA_LoadB = 1'b0;
                Din = 8'h55;
            end
            @(negedge Clk);
            i++;
        end
        check("latency", i, 32'd17);
        for (int k = 0; k < hold; k++) begin
            @(negedge Clk);
            check("hold_no_restart", {30'd0, Busy, Done}, {30'd0, 1'b0, 1'b1});
        end
        Run = 1'b0;
        @(negedge Clk);
        check("back_to_idle", {31'd0, Done}, 32'd0);
    endtask

    initial begin
        @(negedge Clk);
        do_reset();
        check("reset_state", {19'd0, Xval, Aval, Bval, Busy, Done}, 32'd0);

        load(8'h3B);
        check("load_b", {23'd0, Xval, Bval}, {23'd0, 1'b0, 8'h3B});
        run_op(8'h07, {1'b0, 8'h01, 8'h9D}, 0, 1'b0);

        load(8'h3B);
        run_op(8'hF9, {1'b1, 8'hFE, 8'h63}, 0, 1'b0);
        load(8'hC5);
        run_op(8'h07, {1'b1, 8'hFE, 8'h63}, 0, 1'b0);

        load(8'h80);
        run_op(8'h80, {1'b0, 8'h40, 8'h00}, 0, 1'b0);
        load(8'h80);
        run_op(8'h01, {1'b1, 8'hFF, 8'h80}, 0, 1'b0);

        load(8'h03);
        run_op(8'h02, {1'b0, 8'h00, 8'h06}, 0, 1'b0);
        run_op(8'h02, {1'b0, 8'h00, 8'h0C}, 5, 1'b0);

        // Reset seven cycles into an operation aborts it.
        load(8'h3B);
        Run = 1'b1;
        Din = 8'h07;
        repeat (7) @(negedge Clk);
        Reset = 1'b1;
        Run = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        check("midop_reset", {19'd0, Xval, Aval, Bval, Busy, Done}, 32'd0);
        @(negedge Clk);
        check("midop_reset_idle", {30'd0, Busy, Done}, 32'd0);
        load(8'h05);
        run_op(8'h03, {1'b0, 8'h00, 8'h0F}, 0, 1'b0);

        // ClearA_LoadB and Din disturbance while busy must not matter.
        load(8'h3B);
        run_op(8'h07, {1'b0, 8'h01, 8'h9D}, 0, 1'b1);

        // Load and Run together in IDLE: load only.
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        Din = 8'h11;
        @(negedge Clk);
        check("load_priority", {14'd0, Busy, Done, Xval, Aval, Bval},
              {14'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11});
        ClearA_LoadB = 1'b0;
        Run = 1'b0;
        @(negedge Clk);
        check("load_priority_idle", {30'd0, Busy, Done}, 32'd0);

        repeat (2) @(negedge Clk);
        check("queue_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
